fmc_pbit_rx_deser: RTL and testbench

Receive-side deserializer for inter-FPGA p-bit exchange over an FMC/FMC+ link. It accepts the p-bit stream one DATA_WIDTH-wide word per valid cycle and reassembles a full frame in a shadow register. It then commits the frame atomically to a stable p-bit vector that the local p-bit array reads as its remote neighbour states. It sits directly downstream of the link input registers and upstream of the local sampling logic.

---
 rtl/fmc_pbit_rx_deser.sv | 127 ++++++++++++
 tb/tb_fmc_pbit_rx_deser.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fmc_pbit_rx_deser.sv
// fmc_pbit_rx_deser: reassembles link words into a shadow frame and commits it atomically to pbits_out.
module fmc_pbit_rx_deser #(
  parameter int DATA_WIDTH     = 30,
  parameter int NUM_PBITS      = 1369,
  parameter int NUM_WORDS      = (NUM_PBITS + DATA_WIDTH - 1) / DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] link_data,
  input  logic                  link_valid,
  input  logic                  link_sof,
  input  logic                  hold,
  output logic [NUM_PBITS-1:0]  pbits_out,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_sync,
  output logic                  err_timeout,
  output logic                  err_overrun
);
  localparam int WCW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int GCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW  = NUM_WORDS * DATA_WIDTH;
  localparam bit ONE = NUM_WORDS == 1;
  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;
  state_t               state_q, state_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [GCW-1:0]       gap_q, gap_d;
  logic [FW-1:0]        shadow_q, shadow_d;
  logic [NUM_PBITS-1:0] pbits_q, pbits_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 done_q, done_d, sync_q, sync_d, tout_q, tout_d, ovr_q, ovr_d;
  logic                 sof, word;
  assign sof  = link_valid & link_sof;
  assign word = link_valid & ~link_sof;
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    pbits_d  = pbits_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sync_d   = 1'b0;
    tout_d   = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sync_d = word;
        if (sof) begin
          shadow_d[DATA_WIDTH-1:0] = link_data;
          wcnt_d  = WCW'(1);
          gap_d   = '0;
          state_d = ONE ? COMMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (link_valid) begin
          // an SOF mid-frame restarts the frame at word 0
          shadow_d[(link_sof ? 0 : int'(wcnt_q)) * DATA_WIDTH +: DATA_WIDTH] = link_data;
          sync_d = link_sof;
          wcnt_d = link_sof ? WCW'(1) : wcnt_q + WCW'(1);
          gap_d  = '0;
          if (!link_sof && wcnt_q == WCW'(NUM_WORDS - 1)) begin
            state_d = COMMIT;
            wcnt_d  = '0;
          end
        end else begin
          gap_d = gap_q + GCW'(1);
          if (gap_d == GCW'(TIMEOUT_CYCLES)) begin
            tout_d  = 1'b1;
            state_d = IDLE;
            gap_d   = '0;
            wcnt_d  = '0;
          end
        end
      end
      COMMIT: begin
        ovr_d = hold ? link_valid : word;
        if (!hold) begin
          pbits_d = shadow_q[NUM_PBITS-1:0];
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
          wcnt_d  = '0;
          if (sof) begin
            shadow_d[DATA_WIDTH-1:0] = link_data;
            wcnt_d  = WCW'(1);
            gap_d   = '0;
            state_d = ONE ? COMMIT : COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      gap_q   <= '0;
      pbits_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sync_q  <= 1'b0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
      pbits_q <= pbits_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
      tout_q  <= tout_d;
      ovr_q   <= ovr_d;
    end
  end
  assign pbits_out   = pbits_q;
  assign frame_done  = done_q;
  assign frame_count = cnt_q;
  assign err_sync    = sync_q;
  assign err_timeout = tout_q;
  assign err_overrun = ovr_q;
endmodule

// File: tb/tb_fmc_pbit_rx_deser.sv
// tb_fmc_pbit_rx_deser: directed and random stimulus checked every cycle against a frame-level reference model.
module tb_fmc_pbit_rx_deser;
  localparam int DW = 30;
  localparam int NP = 1369;
  localparam int NW = (NP + DW - 1) / DW;
  localparam int TO = 64;
  logic          clk = 1'b0;
  logic          rst, link_valid, link_sof, hold;
  logic [DW-1:0] link_data;
  logic [NP-1:0] pbits_out;
  logic          frame_done, err_sync, err_timeout, err_overrun;
  logic [15:0]   frame_count;
  int            checks = 0, errors = 0;
  logic [DW-1:0] words[NW];
  int            ncol, gap;
  bit            pend;
  logic [NP-1:0] e_pbits;
  logic [15:0]   e_cnt;
  bit            e_done, e_sync, e_to, e_ov;
  always #5 clk = ~clk;
  fmc_pbit_rx_deser dut (
    .clk(clk), .rst(rst), .link_data(link_data), .link_valid(link_valid), .link_sof(link_sof),
    .hold(hold), .pbits_out(pbits_out), .frame_done(frame_done), .frame_count(frame_count),
    .err_sync(err_sync), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );
  function automatic logic [NP-1:0] assemble();
    logic [NW*DW-1:0] f;
    for (int k = 0; k < NW; k++) f[k*DW +: DW] = words[k];
    return f[NP-1:0];
  endfunction
  // frame-level view: ncol words gathered so far, pend = complete frame awaiting release
  task automatic model(input bit v, input bit s, input bit h, input logic [DW-1:0] d, input bit r);
    e_done = 0; e_sync = 0; e_to = 0; e_ov = 0;
    if (r) begin
      pend = 0; ncol = 0; gap = 0; e_pbits = '0; e_cnt = '0;
    end else if (pend) begin
      if (h) e_ov = v;
      else begin
        e_pbits = assemble(); e_done = 1; e_cnt = e_cnt + 16'd1; pend = 0; ncol = 0;
        if (v && s) begin words[0] = d; ncol = 1; gap = 0; end
        else e_ov = v;
      end
    end else if (ncol == 0) begin
      if (v && s) begin words[0] = d; ncol = 1; gap = 0; end
      e_sync = v && !s;
    end else if (v) begin
      e_sync = s;
      if (s) ncol = 0;
      words[ncol] = d; ncol++; gap = 0;
    end else begin
      gap++;
      if (gap == TO) begin e_to = 1; ncol = 0; gap = 0; end
    end
    if (ncol == NW) begin pend = 1; ncol = 0; end
  endtask
  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
    end
  endtask
  task automatic chk_pbits();
    int idx;
    checks++;
    assert (pbits_out === e_pbits) else begin
      idx = 0;
      while (idx < NP - 1 && pbits_out[idx] === e_pbits[idx]) idx++;
      errors++;
      $error("FAIL pbits_out first bad bit %0d got %b exp %b", idx, pbits_out[idx], e_pbits[idx]);
    end
  endtask
  task automatic cyc(input bit v, input bit s, input bit h, input logic [DW-1:0] d, input bit r);
    rst = r; link_valid = v; link_sof = s; hold = h; link_data = d;
    model(v, s, h, d, r);
    @(posedge clk);
    #1;
    chk_pbits();
    chk("frame_done", 64'(frame_done), 64'(e_done));
    chk("frame_count", 64'(frame_count), 64'(e_cnt));
    chk("err_sync", 64'(err_sync), 64'(e_sync));
    chk("err_timeout", 64'(err_timeout), 64'(e_to));
    chk("err_overrun", 64'(err_overrun), 64'(e_ov));
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, '0, 0);
  endtask
  task automatic frame(input int n, input bit sof0);
    for (int k = 0; k < n; k++) cyc(1, sof0 && k == 0, 0, DW'($urandom), 0);
  endtask
  initial begin
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("reset_count", 64'(frame_count), 64'(0));
    for (int k = 0; k < NW; k++) cyc(1, k == 0, 0, DW'(k), 0);
    idle(1);
    chk("full_done", 64'(frame_done), 64'(1));
    chk("full_count", 64'(frame_count), 64'(1));
    chk("full_lo", 64'(pbits_out[DW-1:0]), 64'(0));
    chk("full_hi", 64'(pbits_out[NP-1:(NW-1)*DW]), 64'(45));
    frame(10, 1);
    idle(TO - 1);
    chk("timeout_early", 64'(err_timeout), 64'(0));
    idle(1);
    chk("timeout_pulse", 64'(err_timeout), 64'(1));
    chk("timeout_count", 64'(frame_count), 64'(1));
    frame(NW, 1);
    idle(2);
    chk("after_timeout_count", 64'(frame_count), 64'(2));
    frame(20, 1);
    frame(NW, 1);
    idle(2);
    chk("midsof_count", 64'(frame_count), 64'(3));
    frame(NW - 1, 1);
    cyc(1, 0, 1, DW'($urandom), 0);
    for (int i = 0; i < 5; i++) cyc(i == 2, 0, 1, DW'($urandom), 0);
    chk("hold_no_commit", 64'(frame_count), 64'(3));
    idle(1);
    chk("hold_release_done", 64'(frame_done), 64'(1));
    chk("hold_count", 64'(frame_count), 64'(4));
    for (int f = 0; f < 3; f++) frame(NW, 1);
    idle(2);
    chk("b2b_count", 64'(frame_count), 64'(7));
    frame(30, 1);
    cyc(0, 0, 0, '0, 1);
    chk("rst_pbits", 64'(pbits_out[63:0]), 64'(0));
    cyc(1, 0, 0, DW'($urandom), 0);
    chk("rst_then_sync", 64'(err_sync), 64'(1));
    repeat (20) begin
      frame(NW, 1);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) cyc(0, 0, $urandom_range(0, 1) == 0, '0, 0);
    end
    repeat (3000) cyc($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, DW'($urandom), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
